tone_detector: RTL

//   Receive-side counterpart of the speaker tone generator. Samples a square-wave

---
 rtl/tone_detector_if.sv | 33 +++
 rtl/tone_detector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tone_detector_if.sv
// Bundles the tone line and the measurement results of tone_detector.
// slave = detector side, master = the block driving tone_in and consuming results.
interface tone_detector_if #(
  parameter int CNT_W = 20
);
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [2:0]       note;
  logic             note_hit;
  logic             note_locked;
  logic             silent;

  modport master (
    output tone_in,
    input  period,
    input  period_valid,
    input  note,
    input  note_hit,
    input  note_locked,
    input  silent
  );

  modport slave (
    input  tone_in,
    output period,
    output period_valid,
    output note,
    output note_hit,
    output note_locked,
    output silent
  );
endinterface

// File: rtl/tone_detector.sv
// Measures the rising-to-rising period of a square-wave tone and classifies it
// against the C4..C5 scale; flags lock on repeated matches and silence on timeout.
module tone_detector #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int CNT_W      = 20,
  parameter int TOL_SHIFT  = 5,
  parameter int MIN_PERIOD = 1000,
  parameter int TIMEOUT    = 1_000_000
) (
  input  logic          clk_100mHz,
  input  logic          rst_n,
  tone_detector_if.slave bus
);

  localparam int NOTES = 8;
  localparam int PW    = CNT_W + 1;

  localparam logic [PW-1:0]    MIN_P   = PW'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  function automatic int note_hz(input int idx);
    case (idx)
      0:       return 262;
      1:       return 294;
      2:       return 330;
      3:       return 349;
      4:       return 392;
      5:       return 440;
      6:       return 494;
      default: return 523;
    endcase
  endfunction

  // Synchronizer plus edge-detect flop
  logic s1_reg, s2_reg, s3_reg;
  logic rise;

  always_ff @(posedge clk_100mHz) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= bus.tone_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_sat;
  logic [PW-1:0]    p_cur;
  logic [CNT_W-1:0] period_meas;

  logic [CNT_W-1:0] period_reg, period_next;
  logic             pv_reg, pv_next;
  logic [2:0]       note_reg, note_next;
  logic             hit_reg, hit_next;
  logic             locked_reg, locked_next;
  logic             silent_reg, silent_next;

  // p is one wider than cnt so the all-ones count still measures correctly
  assign p_cur       = PW'(cnt_reg) + PW'(1);
  assign period_meas = p_cur[CNT_W] ? {CNT_W{1'b1}} : p_cur[CNT_W-1:0];
  assign cnt_sat     = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

  // One tolerance window per note; overlapping windows resolve to the lower index
  logic [NOTES-1:0] match;

  for (genvar gi = 0; gi < NOTES; gi++) begin : g_ref
    localparam logic [PW-1:0] REF = PW'(CLK_FREQ / note_hz(gi));
    localparam logic [PW-1:0] TOL = REF >> TOL_SHIFT;
    logic [PW-1:0] diff;

    assign diff       = (p_cur >= REF) ? (p_cur - REF) : (REF - p_cur);
    assign match[gi]  = (diff <= TOL);
  end

  logic       cls_hit;
  logic [2:0] cls_note;

  always_comb begin
    cls_hit  = |match;
    cls_note = 3'd0;
    for (int i = NOTES - 1; i >= 0; i--) begin
      if (match[i]) begin
        cls_note = 3'(i);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    period_next = period_reg;
    pv_next     = 1'b0;
    note_next   = note_reg;
    hit_next    = hit_reg;
    locked_next = locked_reg;
    silent_next = silent_reg;

    case (state_reg)
      IDLE: begin
        // First edge after silence or reset only starts the measurement
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = '0;
        end
      end

      MEASURE: begin
        cnt_next = cnt_sat;
        if (rise && (p_cur >= MIN_P)) begin
          cnt_next    = '0;
          pv_next     = 1'b1;
          period_next = period_meas;
          note_next   = cls_note;
          hit_next    = cls_hit;
          locked_next = cls_hit & hit_reg & (cls_note == note_reg);
          silent_next = 1'b0;
        end else if (!rise && (cnt_reg == TO_LAST)) begin
          state_next  = IDLE;
          cnt_next    = '0;
          hit_next    = 1'b0;
          locked_next = 1'b0;
          silent_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100mHz) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      period_reg <= '0;
      pv_reg     <= 1'b0;
      note_reg   <= 3'd0;
      hit_reg    <= 1'b0;
      locked_reg <= 1'b0;
      silent_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      pv_reg     <= pv_next;
      note_reg   <= note_next;
      hit_reg    <= hit_next;
      locked_reg <= locked_next;
      silent_reg <= silent_next;
    end
  end

  assign bus.period       = period_reg;
  assign bus.period_valid = pv_reg;
  assign bus.note         = note_reg;
  assign bus.note_hit     = hit_reg;
  assign bus.note_locked  = locked_reg;
  assign bus.silent       = silent_reg;

endmodule
